// File: rtl/system_pkg.sv
// rtl/system_pkg.sv - shared APB arbiter constants and FSM state type
package system_pkg;

    localparam int NUM_APB_SLV = 8;
    localparam int APB_SEL_LSB = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// rtl/apb_rr_arb2.sv - two-way round-robin selector with last-grant register
module apb_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    logic r_last;

    // A tie goes to whichever requester did not win the previous grant.
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-requester APB master arbiter; APB_ARB_PREADY_EN adds pready wait states
module apb_arbiter
    import system_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = APB_SEL_LSB
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          m0_req,
    input  logic                          m0_write,
    input  logic [ADDR_W-1:0]             m0_addr,
    input  logic [DATA_W-1:0]             m0_wdata,
    output logic                          m0_gnt,
    output logic                          m0_done,
    output logic [DATA_W-1:0]             m0_rdata,
    input  logic                          m1_req,
    input  logic                          m1_write,
    input  logic [ADDR_W-1:0]             m1_addr,
    input  logic [DATA_W-1:0]             m1_wdata,
    output logic                          m1_gnt,
    output logic                          m1_done,
    output logic [DATA_W-1:0]             m1_rdata,
    output logic [ADDR_W-1:0]             paddr,
    output logic                          pwrite,
    output logic [DATA_W-1:0]             pwdata,
    output logic                          penable,
    output logic [NUM_APB_SLV-1:0]        psel,
`ifdef APB_ARB_PREADY_EN
    input  logic                          pready,
`endif
    input  logic [NUM_APB_SLV*DATA_W-1:0] prdata
);

    apb_arb_state_e r_state, w_next;

    logic              r_owner;
    logic              r_done0, r_done1;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic [1:0]             w_req;
    logic [1:0]             w_arb_gnt;
    logic                   w_start;
    logic                   w_ready;
    logic                   w_finish;
    logic [2:0]             w_sel;
    logic [NUM_APB_SLV-1:0] w_onehot;
    logic [DATA_W-1:0]      w_prd;

`ifdef APB_ARB_PREADY_EN
    assign w_ready = pready;
`else
    assign w_ready = 1'b1;
`endif

    // A requester whose done is showing cannot win again in that same cycle.
    assign w_req    = {m1_req & ~r_done1, m0_req & ~r_done0};
    assign w_start  = (r_state == IDLE) && (|w_req);
    assign w_finish = (r_state == ACCESS) && w_ready;
    assign w_sel    = r_paddr[SEL_LSB +: 3];

    apb_rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rstn),
        .i_req  (w_req),
        .i_take (w_start),
        .o_gnt  (w_arb_gnt)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
        w_prd           = '0;
        for (int k = 0; k < NUM_APB_SLV; k++) begin
            if (w_sel == 3'(k)) begin
                w_prd = prdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_owner  <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_start) begin
                r_owner  <= w_arb_gnt[1];
                r_paddr  <= w_arb_gnt[1] ? m1_addr  : m0_addr;
                r_pwrite <= w_arb_gnt[1] ? m1_write : m0_write;
                r_pwdata <= w_arb_gnt[1] ? m1_wdata : m0_wdata;
            end
            if (w_finish) begin
                if (r_owner) begin
                    r_done1 <= 1'b1;
                    if (!r_pwrite) r_rdata1 <= w_prd;
                end else begin
                    r_done0 <= 1'b1;
                    if (!r_pwrite) r_rdata0 <= w_prd;
                end
            end
        end
    end

    assign paddr    = r_paddr;
    assign pwrite   = r_pwrite;
    assign pwdata   = r_pwdata;
    assign penable  = (r_state == ACCESS);
    assign psel     = (r_state != IDLE) ? w_onehot : '0;
    assign m0_gnt   = (r_state != IDLE) && !r_owner;
    assign m1_gnt   = (r_state != IDLE) &&  r_owner;
    assign m0_done  = r_done0;
    assign m1_done  = r_done1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - directed table-driven bench for apb_arbiter
module tb_apb_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic         m0_req, m0_write, m1_req, m1_write;
    logic [31:0]  m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic         m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0]  m0_rdata, m1_rdata;
    logic [31:0]  paddr, pwdata;
    logic         pwrite, penable;
    logic [7:0]   psel;
    logic [255:0] prdata;
`ifdef APB_ARB_PREADY_EN
    logic         pready;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .m0_req   (m0_req),
        .m0_write (m0_write),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_done  (m0_done),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_write (m1_write),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_done  (m1_done),
        .m1_rdata (m1_rdata),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .penable  (penable),
        .psel     (psel),
`ifdef APB_ARB_PREADY_EN
        .pready   (pready),
`endif
        .prdata   (prdata)
    );

    typedef struct {
        bit          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  exp_psel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
    endtask

    task automatic set_m(input bit m, input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            m1_req = req; m1_write = wr; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_write = wr; m0_addr = a; m0_wdata = d;
        end
    endtask

    logic [1:0] gnt_pair;
    logic [1:0] done_pair;
    logic [31:0] rd_sel;
    int order[$];
    int m0_dones;
    bit prev_done0;

    initial begin
        rstn = 1'b1;
        m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
`ifdef APB_ARB_PREADY_EN
        pready = 1'b1;
`endif
        for (int k = 0; k < 8; k++) prdata[k*32 +: 32] = 32'h11 * (k + 1);

        vecs[0] = '{0, 1, 32'h0000_1004, 32'hA5A5_0001, 8'b0000_0010, 32'h0000_0000};
        vecs[1] = '{1, 0, 32'h0000_7010, 32'h0,         8'b1000_0000, 32'h0000_0088};
        vecs[2] = '{0, 0, 32'h0000_3000, 32'h0,         8'b0000_1000, 32'h0000_0044};
        vecs[3] = '{1, 1, 32'h0000_5FFC, 32'h1234_5678, 8'b0010_0000, 32'h0000_0088};
        vecs[4] = '{0, 0, 32'hFFFF_0FFF, 32'h0,         8'b0000_0001, 32'h0000_0011};
        vecs[5] = '{1, 0, 32'h0000_4000, 32'h0,         8'b0001_0000, 32'h0000_0055};
        vecs[6] = '{0, 1, 32'h0000_6008, 32'hDEAD_BEEF, 8'b0100_0000, 32'h0000_0011};
        vecs[7] = '{0, 0, 32'h0000_2000, 32'h0,         8'b0000_0100, 32'h0000_0033};

        tick();
        chk("rst_psel", psel, 8'h00);
        chk("rst_penable", penable, 1'b0);
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst_done", {m1_done, m0_done}, 2'b00);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        rstn = 1'b0;

        // Single transfers, one requester at a time, zero wait states.
        for (int i = 0; i < 8; i++) begin
            set_m(vecs[i].m, 1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_idle_psel", i), psel, 8'h00);
            tick();
            gnt_pair = vecs[i].m ? 2'b10 : 2'b01;
            chk($sformatf("v%0d_setup_psel", i), psel, vecs[i].exp_psel);
            chk($sformatf("v%0d_setup_penable", i), penable, 1'b0);
            chk($sformatf("v%0d_setup_gnt", i), {m1_gnt, m0_gnt}, gnt_pair);
            chk($sformatf("v%0d_paddr", i), paddr, vecs[i].addr);
            chk($sformatf("v%0d_pwrite", i), pwrite, vecs[i].wr);
            tick();
            chk($sformatf("v%0d_access_psel", i), psel, vecs[i].exp_psel);
            chk($sformatf("v%0d_access_penable", i), penable, 1'b1);
            chk($sformatf("v%0d_access_gnt", i), {m1_gnt, m0_gnt}, gnt_pair);
            chk($sformatf("v%0d_access_done", i), {m1_done, m0_done}, 2'b00);
            tick();
            chk($sformatf("v%0d_done", i), {m1_done, m0_done}, gnt_pair);
            chk($sformatf("v%0d_done_psel", i), psel, 8'h00);
            chk($sformatf("v%0d_done_gnt", i), {m1_gnt, m0_gnt}, 2'b00);
            rd_sel = vecs[i].m ? m1_rdata : m0_rdata;
            chk($sformatf("v%0d_rdata", i), rd_sel, vecs[i].exp_rdata);
            if (vecs[i].wr) chk($sformatf("v%0d_pwdata", i), pwdata, vecs[i].wdata);
            set_m(vecs[i].m, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            chk($sformatf("v%0d_done_cleared", i), {m1_done, m0_done}, 2'b00);
        end

        // Simultaneous reads after reset: m0 first, m1 three cycles later.
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
        tick();
        chk("tie_first_gnt", {m1_gnt, m0_gnt}, 2'b01);
        tick();
        tick();
        chk("tie_m0_done", {m1_done, m0_done}, 2'b01);
        chk("tie_m0_rdata", m0_rdata, 32'h11);
        m0_req = 1'b0;
        tick();
        chk("tie_second_gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("tie_second_psel", psel, 8'b0000_0100);
        tick();
        tick();
        chk("tie_m1_done", {m1_done, m0_done}, 2'b10);
        chk("tie_m1_rdata", m1_rdata, 32'h33);
        m1_req = 1'b0;
        tick();

        // m0 holds req for three transfers while m1 asks once.
        do_reset();
        order.delete();
        m0_dones = 0;
        prev_done0 = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (prev_done0) chk("rr_no_regrant_m0", m0_gnt, 1'b0);
            if (psel != 8'h00 && !penable) order.push_back(m1_gnt ? 1 : 0);
            if (m1_done) m1_req = 1'b0;
            if (m0_done) begin
                m0_dones++;
                if (m0_dones == 3) m0_req = 1'b0;
            end
            prev_done0 = m0_done;
        end
        chk("rr_m0_done_count", m0_dones, 3);
        chk("rr_grant_count", order.size(), 4);
        if (order.size() >= 3) begin
            chk("rr_order0", order[0], 0);
            chk("rr_order1", order[1], 1);
            chk("rr_order2", order[2], 0);
        end

`ifdef APB_ARB_PREADY_EN
        // Four wait states: ACCESS held five cycles, done after pready rises.
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0000_6004, 32'h0);
        tick();
        pready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ws%0d_penable", i), penable, 1'b1);
            chk($sformatf("ws%0d_psel", i), psel, 8'b0100_0000);
            chk($sformatf("ws%0d_paddr", i), paddr, 32'h0000_6004);
            chk($sformatf("ws%0d_done", i), m0_done, 1'b0);
            if (i == 4) pready = 1'b1;
        end
        tick();
        chk("ws_done", m0_done, 1'b1);
        chk("ws_rdata", m0_rdata, 32'h77);
        m0_req = 1'b0;
        tick();
`endif

        // Reset during ACCESS aborts the transfer and restores m0 priority.
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
        tick();
        tick();
        chk("abort_in_access", penable, 1'b1);
        rstn = 1'b1;
        #1;
        chk("abort_psel", psel, 8'h00);
        chk("abort_penable", penable, 1'b0);
        chk("abort_gnt", {m1_gnt, m0_gnt}, 2'b00);
        m0_req = 1'b0;
        tick();
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_no_done", {m1_done, m0_done}, 2'b00);
        end
        set_m(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
        tick();
        chk("abort_next_gnt", {m1_gnt, m0_gnt}, 2'b01);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter SEL_LSB, default 12, LSB of the 3-bit slave-select field in the address.
REQ-004 SHALL have ports: clk  in  1  single clock; rstn  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: m0_req in 1, m0_write in 1, m0_addr in ADDR_W, m0_wdata in DATA_W; requester 0 holds these stable until m0_done.
REQ-006 SHALL have ports: m0_gnt out 1 (transfer owner), m0_done out 1 (one-cycle completion pulse), m0_rdata out DATA_W (read data, valid with m0_done).
REQ-007 SHALL have m1_* ports identical to m0_* for requester 1.
REQ-008 SHALL have ports: paddr out ADDR_W, pwrite out 1, pwdata out DATA_W, penable out 1, psel out 8 (one-hot, bit k = slave k+1).
REQ-009 SHALL have port prdata in 8xDATA_W, packed, entry k = slave k+1 read data.
REQ-010 SHALL have port pready in 1 only when APB_ARB_PREADY_EN is defined.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS; IDLE->SETUP on any unmasked request, SETUP->ACCESS unconditionally, ACCESS->IDLE on completion.
REQ-012 SHALL arbitrate in IDLE only; single request -> that requester; both -> requester not granted last (round-robin).
REQ-013 SHALL register addr/write/wdata of the winner into paddr/pwrite/pwdata on IDLE->SETUP and hold them through ACCESS.
REQ-014 SHALL drive psel[SEL field of paddr] high in SETUP and ACCESS, all psel low in IDLE; penable high only in ACCESS.
REQ-015 SHALL assert mX_gnt from SETUP through ACCESS for the winner only; never both gnt high.
REQ-016 SHALL capture prdata entry of the selected slave into mX_rdata on ACCESS completion; writes leave mX_rdata unchanged.
REQ-017 SHALL pulse mX_done for exactly the one IDLE cycle following ACCESS; requester drops req in that cycle.
REQ-018 SHALL mask mX_req of the requester whose done is high in that cycle, so a still-high req is not re-granted; the other requester may win in that same cycle.
REQ-019 Latency: req sampled in IDLE at cycle N -> SETUP N+1 -> ACCESS N+2 -> done N+3 (zero wait states); back-to-back transfers from alternating requesters every 3 cycles.
REQ-020 SHALL ignore requests arriving during SETUP/ACCESS until next IDLE; no request queueing.

Reset
REQ-021 rstn high SHALL asynchronously force state IDLE; psel, penable, pwrite, paddr, pwdata, gnt, done, rdata all 0; last-grant = requester 1 (requester 0 wins first tie).
REQ-022 Reset asserted mid-transfer SHALL abort it with no done pulse; first arbitration after release follows REQ-021 priority.

Configuration
REQ-023 Macro APB_ARB_PREADY_EN defined: pready port exists; ACCESS holds (all outputs stable) while pready low, completes on first cycle pready high.
REQ-024 Macro undefined: no pready port; ACCESS always completes after one cycle.

Structure
REQ-025 system_pkg SHALL hold NUM_APB_SLV (8), APB_SEL_LSB (12) and typedef apb_arb_state_e {IDLE, SETUP, ACCESS}.
REQ-026 Two-way round-robin selection with last-grant register SHALL be sub-module apb_rr_arb2; FSM, datapath and decode remain in apb_arbiter.

Verification
REQ-027 m0 write addr 0x0000_1004 data 0xA5A5_0001 -> psel=8'b0000_0010 cycle N+1, penable N+2, m0_done N+3, pwdata=0xA5A5_0001.
REQ-028 m0 and m1 reads requested together after reset, slave1 prdata 0x11, slave3 0x33 -> m0 served first (rdata 0x11), m1 next (rdata 0x33), done pulses 3 cycles apart.
REQ-029 m0 holds req for 3 consecutive transfers while m1 requests once -> order m0, m1, m0; m0 never re-granted in its own done cycle.
REQ-030 APB_ARB_PREADY_EN defined, pready low 4 cycles in ACCESS -> penable/psel/paddr stable 5 ACCESS cycles, done 1 cycle after pready high.
REQ-031 rstn asserted during ACCESS -> psel/penable/gnt 0 same cycle, no done pulse; next simultaneous request grants m0.
